// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: decode inputs, forwarding sources and EX-side outputs.
// bubble_count exists only when IDEX_BUBBLE_CNT_EN is defined.
interface id_ex_stage_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  logic          id_valid;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic [RW-1:0] id_rd;
  logic [DW-1:0] id_rs_data;
  logic [DW-1:0] id_rt_data;
  logic [DW-1:0] id_imm;
  logic [2:0]    id_alu_control;
  logic          id_alu_src;
  logic          id_reg_dst;
  logic          id_reg_write;
  logic          id_mem_read;
  logic          id_mem_write;
  logic          id_mem_to_reg;
  logic          flush;
  logic          hold;
  logic          mem_reg_write;
  logic [RW-1:0] mem_rd;
  logic [DW-1:0] mem_result;
  logic          wb_reg_write;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_result;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [2:0]    alu_control;
  logic          ex_valid;
  logic [RW-1:0] ex_dest;
  logic          ex_reg_write;
  logic          ex_mem_read;
  logic          ex_mem_write;
  logic          ex_mem_to_reg;
  logic [DW-1:0] ex_store_data;
  logic          load_use_stall;
`ifdef IDEX_BUBBLE_CNT_EN
  logic [31:0]   bubble_count;
`endif

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
           id_alu_control, id_alu_src, id_reg_dst, id_reg_write, id_mem_read,
           id_mem_write, id_mem_to_reg, flush, hold,
           mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_result,
    output alu_a, alu_b, alu_control, ex_valid, ex_dest, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_store_data, load_use_stall
`ifdef IDEX_BUBBLE_CNT_EN
    , output bubble_count
`endif
  );

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
           id_alu_control, id_alu_src, id_reg_dst, id_reg_write, id_mem_read,
           id_mem_write, id_mem_to_reg, flush, hold,
           mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_result,
    input  alu_a, alu_b, alu_control, ex_valid, ex_dest, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_store_data, load_use_stall
`ifdef IDEX_BUBBLE_CNT_EN
    , input bubble_count
`endif
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB forwarding and load-use detection.
// Optional bubble counter enabled by defining IDEX_BUBBLE_CNT_EN.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  id_ex_stage_if.slave  bus
);

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] dest;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [2:0]    alu_control;
    logic          alu_src;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          mem_to_reg;
  } stage_t;

  stage_t        r_stage;
  stage_t        w_next;
  logic          w_stall;
  logic [DW-1:0] w_fwd_rs;
  logic [DW-1:0] w_fwd_rt;

  // rt is compared even for I-type consumers; a spurious stall is harmless.
  assign w_stall = bus.id_valid & r_stage.valid & r_stage.mem_read &
                   (r_stage.dest != '0) &
                   ((r_stage.dest == bus.id_rs) | (r_stage.dest == bus.id_rt));

  always_comb begin
    w_fwd_rs = r_stage.rs_data;
    if (bus.mem_reg_write && (bus.mem_rd != '0) && (bus.mem_rd == r_stage.rs))
      w_fwd_rs = bus.mem_result;
    else if (bus.wb_reg_write && (bus.wb_rd != '0) && (bus.wb_rd == r_stage.rs))
      w_fwd_rs = bus.wb_result;
  end

  always_comb begin
    w_fwd_rt = r_stage.rt_data;
    if (bus.mem_reg_write && (bus.mem_rd != '0) && (bus.mem_rd == r_stage.rt))
      w_fwd_rt = bus.mem_result;
    else if (bus.wb_reg_write && (bus.wb_rd != '0) && (bus.wb_rd == r_stage.rt))
      w_fwd_rt = bus.wb_result;
  end

  always_comb begin
    w_next = r_stage;
    if (bus.flush) begin
      w_next = '0;
    end else if (bus.hold) begin
      // Absorb the WB write while frozen so the operand survives WB retiring.
      if (bus.wb_reg_write && (bus.wb_rd != '0)) begin
        if (r_stage.rs == bus.wb_rd) w_next.rs_data = bus.wb_result;
        if (r_stage.rt == bus.wb_rd) w_next.rt_data = bus.wb_result;
      end
    end else if (w_stall || !bus.id_valid) begin
      w_next = '0;
    end else begin
      w_next.valid       = 1'b1;
      w_next.rs          = bus.id_rs;
      w_next.rt          = bus.id_rt;
      w_next.dest        = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
      w_next.rs_data     = bus.id_rs_data;
      w_next.rt_data     = bus.id_rt_data;
      w_next.imm         = bus.id_imm;
      w_next.alu_control = bus.id_alu_control;
      w_next.alu_src     = bus.id_alu_src;
      w_next.reg_write   = bus.id_reg_write & bus.id_valid;
      w_next.mem_read    = bus.id_mem_read & bus.id_valid;
      w_next.mem_write   = bus.id_mem_write & bus.id_valid;
      w_next.mem_to_reg  = bus.id_mem_to_reg & bus.id_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_stage <= '0;
    else        r_stage <= w_next;
  end

  assign bus.alu_a          = w_fwd_rs;
  assign bus.alu_b          = r_stage.alu_src ? r_stage.imm : w_fwd_rt;
  assign bus.ex_store_data  = w_fwd_rt;
  assign bus.alu_control    = r_stage.alu_control;
  assign bus.ex_valid       = r_stage.valid;
  assign bus.ex_dest        = r_stage.dest;
  assign bus.ex_reg_write   = r_stage.reg_write;
  assign bus.ex_mem_read    = r_stage.mem_read;
  assign bus.ex_mem_write   = r_stage.mem_write;
  assign bus.ex_mem_to_reg  = r_stage.mem_to_reg;
  assign bus.load_use_stall = w_stall;

`ifdef IDEX_BUBBLE_CNT_EN
  logic [31:0] r_bubble_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_bubble_count <= '0;
    else if (bus.flush || (!bus.hold && w_stall))
      r_bubble_count <= r_bubble_count + 32'd1;
  end

  assign bus.bubble_count = r_bubble_count;
`endif

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage MIPS core. Sits directly upstream of the ALU.
- Latches decoded operands and control from ID.
- Resolves RAW hazards by forwarding from MEM/WB and detects load-use hazards.
- Drives the ALU operand/control inputs (a, b, alu_control) and the EX/MEM side-band fields.

Parameters:
- DW, 32, datapath width.
- RW, 5, register-index width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt, id_rd  in  RW each  source/destination indices.
- id_rs_data, id_rt_data  in  DW each  register-file read data.
- id_imm  in  DW  sign-extended immediate.
- id_alu_control  in  3  000 add, 001 sub, 010 and, 011 or, 100 slt.
- id_alu_src  in  1  1 selects the immediate for ALU b.
- id_reg_dst  in  1  1 selects rd as destination, 0 selects rt.
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  control bits.
- flush  in  1  branch/jump squash of the instruction entering EX.
- hold  in  1  downstream freeze (memory wait).
- mem_reg_write  in  1, mem_rd  in  RW, mem_result  in  DW  EX/MEM forwarding source.
- wb_reg_write  in  1, wb_rd  in  RW, wb_result  in  DW  MEM/WB forwarding source.
- alu_a, alu_b  out  DW each  ALU operands.
- alu_control  out  3  ALU operation.
- ex_valid  out  1  EX slot is a real instruction.
- ex_dest  out  RW  resolved destination register.
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each  registered control bits.
- ex_store_data  out  DW  forwarded rt value, for sw.
- load_use_stall  out  1  to PC/IF-ID: hold fetch/decode.

Behaviour:
- Reset (rst_n=0, async): all registered fields clear to 0, including ex_valid, control bits, indices, data, imm and alu_control.
  - Consequence: alu_a=0, alu_b=0, alu_control=000, load_use_stall=0.
- Registered fields: valid, rs, rt, dest, rs_data, rt_data, imm, alu_control, alu_src, reg_write, mem_read, mem_write, mem_to_reg.
  - dest = id_reg_dst ? id_rd : id_rt, resolved at capture.
- Update priority at each posedge, highest first:
  1. flush: insert a bubble.
  2. hold: retain current contents (operand refresh still applies).
  3. load_use_stall: insert a bubble.
  4. Otherwise: capture ID. Control bits are ANDed with id_valid, so id_valid=0 captures as a bubble.
- Bubble: every registered field zeroed, identical to the reset image.
- Load-use hazard, combinational:
  - load_use_stall = id_valid & ex_valid & ex_mem_read & (ex_dest != 0) & ((ex_dest == id_rs) | (ex_dest == id_rt)).
  - Conservative: rt is always compared.
  - Asserted for exactly one cycle per hazard unless hold is also high. Under hold it stays high while the condition persists.
- Forwarding, combinational, applied to the registered rs and rt independently:
  - If mem_reg_write & mem_rd != 0 & mem_rd == idx, select mem_result.
  - Else if wb_reg_write & wb_rd != 0 & wb_rd == idx, select wb_result.
  - Else select the registered data.
  - MEM has priority over WB. Register 0 is never forwarded.
- Operand refresh: on any edge where the stage retains contents (hold=1, flush=0), write wb_result into the stored rs_data/rt_data whose index matches wb_rd (wb_reg_write=1, wb_rd != 0). This prevents stale operands after WB retires during a freeze.
- Output derivation:
  - alu_a = fwd_rs.
  - alu_b = alu_src ? imm : fwd_rt.
  - ex_store_data = fwd_rt.
  - alu_control, ex_* = registered values.
- Latency: one cycle from ID capture to ALU inputs. Forwarding adds no cycles.
- Reset mid-stall or mid-hold: immediate clear. load_use_stall drops asynchronously, since ex_valid becomes 0.

Optional Feature:
- Macro: IDEX_BUBBLE_CNT_EN.
- Defined: adds output bubble_count [31:0].
  - Increments once per posedge that inserts a bubble due to flush or load_use_stall (not for id_valid=0).
  - Wraps from 0xFFFFFFFF to 0. Cleared by rst_n.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with random inputs -> all outputs 0 immediately; after release with id_valid=0, ex_valid stays 0.
- Simple capture: add, rs_data=5, rt_data=7, alu_src=0 -> next cycle alu_a=5, alu_b=7, alu_control=000, ex_dest=rd. Then addi, imm=0xFFFFFFFC -> alu_b=0xFFFFFFFC.
- Forwarding priority: EX rs=3; mem_rd=3, mem_result=0x11; wb_rd=3, wb_result=0x22 -> alu_a=0x11. Drop mem_reg_write -> 0x22. Set rd index 0 on both -> registered data.
- Load-use: lw to $4 in EX, next ID uses rt=$4 -> load_use_stall=1 for one cycle, bubble enters EX (ex_valid=0, ex_reg_write=0), then the dependent instruction captures; bubble_count=1 if enabled.
- Flush vs hold: flush=1 and hold=1 on the same edge -> bubble. hold=1 alone for 3 cycles -> contents unchanged, alu_control stable.
- Hold refresh: hold=1 with EX rs=$8; wb writes $8=0xABCD; wb then advances -> alu_a remains 0xABCD after hold releases.
